// File: rtl/text_token_buffer.sv
// Sentence buffer: strips leading/repeated delimiters, optionally folds upper case,
// stores characters tagged with end-of-word and drains them once the sentence closes.
module text_token_buffer #(
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       DEPTH     = 64,
    parameter logic [DATA_W-1:0] DELIM     = DATA_W'(8'h20),
    parameter bit                FOLD_CASE = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     wr_last,
    output logic                     wr_rdy,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_eow,
    output logic                     rd_eos,
    output logic [$clog2(DEPTH):0]   word_count,
    output logic                     overflow,
    output logic                     sdone
);

    localparam int unsigned       AW       = $clog2(DEPTH);
    localparam int unsigned       CW       = AW + 1;
    localparam logic [CW-1:0]     FULL     = CW'(DEPTH);
    localparam logic [DATA_W-1:0] UC_LO    = DATA_W'(8'h41);
    localparam logic [DATA_W-1:0] UC_HI    = DATA_W'(8'h5A);
    localparam logic [DATA_W-1:0] CASE_OFS = DATA_W'(8'h20);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [DATA_W:0]   mem [DEPTH];
    logic [AW-1:0]     wptr, wptr_nxt;
    logic [AW-1:0]     rptr, rptr_nxt;
    logic [CW-1:0]     count, count_nxt;
    logic [CW-1:0]     wc_nxt;
    logic [DATA_W-1:0] pend, pend_nxt;
    logic              pend_v, pend_v_nxt;
    logic              ovf_nxt;
    logic              mem_we;
    logic [DATA_W:0]   mem_wdata;
    logic              accept;
    logic [DATA_W-1:0] folded;

    // Status and first-word fall-through read port derived from the registered state.
    assign wr_rdy   = ((state == ST_FILL) || (state == ST_DONE)) && (count < FULL);
    assign rd_valid = (state == ST_DRAIN) && (count != '0);
    assign rd_data  = rd_valid ? mem[rptr][DATA_W-1:0] : '0;
    assign rd_eow   = rd_valid & mem[rptr][DATA_W];
    assign rd_eos   = rd_valid && (count == CW'(1));
    assign sdone    = (state == ST_DONE);
    assign accept   = wr_en & wr_rdy;
    assign folded   = (FOLD_CASE && (wr_data >= UC_LO) && (wr_data <= UC_HI))
                      ? wr_data + CASE_OFS : wr_data;

    // Next-state logic: the pending character is committed once its word tag is known.
    always_comb begin
        state_nxt  = state;
        wptr_nxt   = wptr;
        rptr_nxt   = rptr;
        count_nxt  = count;
        pend_nxt   = pend;
        pend_v_nxt = pend_v;
        wc_nxt     = word_count;
        ovf_nxt    = overflow;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        unique case (state)
            ST_FILL, ST_DONE: begin
                if (accept) begin
                    if (state == ST_DONE) begin
                        state_nxt = ST_FILL;
                        wc_nxt    = '0;
                        ovf_nxt   = 1'b0;
                    end
                    if (wr_data == DELIM) begin
                        if (pend_v) begin
                            mem_we     = 1'b1;
                            mem_wdata  = {1'b1, pend};
                            wc_nxt     = wc_nxt + CW'(1);
                            pend_v_nxt = 1'b0;
                        end
                    end else begin
                        if (pend_v) begin
                            mem_we    = 1'b1;
                            mem_wdata = {1'b0, pend};
                        end
                        pend_nxt   = folded;
                        pend_v_nxt = 1'b1;
                    end
                end else if (wr_en) begin
                    ovf_nxt = 1'b1;
                end
                if (wr_last) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (pend_v) begin
                    wc_nxt     = word_count + CW'(1);
                    pend_v_nxt = 1'b0;
                    if (count < FULL) begin
                        mem_we    = 1'b1;
                        mem_wdata = {1'b1, pend};
                    end else begin
                        ovf_nxt = 1'b1;
                    end
                end
                state_nxt = ((count != '0) || mem_we) ? ST_DRAIN : ST_DONE;
            end
            ST_DRAIN: begin
                if (rd_valid && rd_en) begin
                    rptr_nxt  = rptr + AW'(1);
                    count_nxt = count - CW'(1);
                    if (count == CW'(1)) begin
                        state_nxt = ST_DONE;
                    end
                end else if (count == '0) begin
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_FILL;
        endcase
        if (mem_we) begin
            wptr_nxt  = wptr + AW'(1);
            count_nxt = count + CW'(1);
        end
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_FILL;
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            pend       <= '0;
            pend_v     <= 1'b0;
            word_count <= '0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_nxt;
            wptr       <= wptr_nxt;
            rptr       <= rptr_nxt;
            count      <= count_nxt;
            pend       <= pend_nxt;
            pend_v     <= pend_v_nxt;
            word_count <= wc_nxt;
            overflow   <= ovf_nxt;
        end
    end

    // Character storage, not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wptr] <= mem_wdata;
        end
    end

endmodule
